// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor and its synchronizer.
// Phase-counter sizing and saturating increment live here so every user agrees on them.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RST_PLL   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } sup_state_t;

    // The phase counter only ever reaches max-1, so clog2(max) bits suffice.
    function automatic int unsigned phase_w(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] maxv;
        maxv = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// Two-flop synchronizer for asynchronous status inputs; both flops clear on reset.
module pll_sup_sync2 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= '0;
            q       <= '0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, releases sys_rst, tracks lock loss.
// Define PLL_SUP_STATS_EN to build the saturating timeout/loss counters; otherwise they read 0.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    localparam int unsigned PH_W = phase_w(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [PH_W-1:0] RST_LAST = PH_W'(PLL_RST_CYCLES - 1);
    localparam logic [PH_W-1:0] TO_LAST  = PH_W'(LOCK_TIMEOUT - 1);
    localparam logic [PH_W-1:0] STB_LAST = PH_W'(STABLE_CYCLES - 1);

    sup_state_t      state;
    sup_state_t      nxt;
    logic [PH_W-1:0] ph;
    logic            locked_s;
    logic            pll_rst_d;
    logic            sys_rst_d;

    pll_sup_sync2 #(.DATA_W(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // Single phase counter, restarted on every state change.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= RST_PLL;
            ph    <= '0;
        end else begin
            state <= nxt;
            ph    <= (nxt != state) ? '0 : ph + PH_W'(1);
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            RST_PLL:   if (ph == RST_LAST) nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s)            nxt = STABLE;
                else if (ph == TO_LAST)  nxt = RST_PLL;
            end
            STABLE: begin
                if (!locked_s)           nxt = WAIT_LOCK;
                else if (ph == STB_LAST) nxt = RUN;
            end
            RUN:       if (!locked_s) nxt = WAIT_LOCK;
            default:   nxt = RST_PLL;
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        pll_rst_d = (nxt == RST_PLL);
        sys_rst_d = (nxt != RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            pll_rst <= pll_rst_d;
            sys_rst <= sys_rst_d;
            ready   <= ~sys_rst_d;
        end
    end

`ifdef PLL_SUP_STATS_EN
    logic             timeout_evt;
    logic             loss_evt;
    logic [CNT_W-1:0] timeout_q;
    logic [CNT_W-1:0] loss_q;

    // A lock arriving on the timeout cycle wins, so the timeout only counts with locked_s low.
    assign timeout_evt = (state == WAIT_LOCK) && !locked_s && (ph == TO_LAST);
    assign loss_evt    = (state == RUN) && !locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            timeout_q <= '0;
            loss_q    <= '0;
        end else begin
            if (timeout_evt) timeout_q <= CNT_W'(sat_inc(32'(timeout_q), CNT_W));
            if (loss_evt)    loss_q    <= CNT_W'(sat_inc(32'(loss_q), CNT_W));
        end
    end

    assign timeout_cnt = timeout_q;
    assign loss_cnt    = loss_q;
`else
    assign timeout_cnt = '0;
    assign loss_cnt    = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters (4/32/8/4).
// Cycle k is the observation taken after k reset-free rising edges.
module tb_pll_lock_supervisor;

    localparam int PR = 4;
    localparam int LT = 32;
    localparam int SC = 8;
    localparam int CW = 4;

    logic          refclk = 1'b0;
    logic          rst    = 1'b1;
    logic          locked = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [CW-1:0] timeout_cnt;
    logic [CW-1:0] loss_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (PR),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .CNT_W          (CW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .timeout_cnt (timeout_cnt),
        .loss_cnt    (loss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Expected statistics value: counters read 0 when the feature is not built.
    function automatic int st(input int v);
`ifdef PLL_SUP_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic tick();
        @(posedge refclk);
        cyc++;
        @(negedge refclk);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset(input logic lk);
        rst    = 1'b1;
        locked = lk;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic check_release_seq(input string pfx);
        check({pfx, "_rst_pll"}, 32'(pll_rst), 1);
        check({pfx, "_rst_sys"}, 32'(sys_rst), 1);
        check({pfx, "_rst_rdy"}, 32'(ready), 0);
        check({pfx, "_rst_tcnt"}, 32'(timeout_cnt), 0);
        check({pfx, "_rst_lcnt"}, 32'(loss_cnt), 0);
        run_until(PR - 1);
        check({pfx, "_pll_c3"}, 32'(pll_rst), 1);
        run_until(PR);
        check({pfx, "_pll_c4"}, 32'(pll_rst), 0);
        run_until(PR + SC);
        check({pfx, "_sys_c12"}, 32'(sys_rst), 1);
        run_until(PR + SC + 1);
        check({pfx, "_sys_c13"}, 32'(sys_rst), 0);
        check({pfx, "_rdy_c13"}, 32'(ready), 1);
    endtask

    initial begin
        // Lock held high from reset.
        do_reset(1'b1);
        check_release_seq("s1");
        run_until(20);
        check("s1_tcnt", 32'(timeout_cnt), 0);
        check("s1_lcnt", 32'(loss_cnt), 0);
        check("s1_pll_run", 32'(pll_rst), 0);

        // Lock never asserted: timeouts every 36 cycles, saturating at 15.
        do_reset(1'b0);
        run_until(PR);
        check("s2_pll_c4", 32'(pll_rst), 0);
        for (int n = 1; n <= 20; n++) begin
            run_until(36 * n - 1);
            check("s2_tcnt_pre", 32'(timeout_cnt), st((n - 1 > 15) ? 15 : n - 1));
            check("s2_pll_pre", 32'(pll_rst), 0);
            run_until(36 * n);
            check("s2_tcnt_post", 32'(timeout_cnt), st((n > 15) ? 15 : n));
            check("s2_pll_post", 32'(pll_rst), 1);
            run_until(36 * n + PR - 1);
            check("s2_pll_end", 32'(pll_rst), 1);
            run_until(36 * n + PR);
            check("s2_pll_off", 32'(pll_rst), 0);
            check("s2_sys", 32'(sys_rst), 1);
        end
        run_until(36 * 20 + 20);
        check("s2_tcnt_sat", 32'(timeout_cnt), st(15));
        check("s2_rdy", 32'(ready), 0);

        // One-cycle lock glitch seen at STABLE count 5.
        do_reset(1'b1);
        run_until(8);
        locked = 1'b0;
        tick();
        locked = 1'b1;
        run_until(13);
        check("s3_sys_c13", 32'(sys_rst), 1);
        run_until(19);
        check("s3_sys_c19", 32'(sys_rst), 1);
        run_until(20);
        check("s3_sys_c20", 32'(sys_rst), 0);
        check("s3_rdy_c20", 32'(ready), 1);
        check("s3_tcnt", 32'(timeout_cnt), 0);

        // Runtime loss of lock for 3 cycles starting at cycle 20.
        do_reset(1'b1);
        run_until(20);
        check("s4_rdy_c20", 32'(ready), 1);
        locked = 1'b0;
        run_until(22);
        check("s4_sys_c22", 32'(sys_rst), 0);
        run_until(23);
        check("s4_sys_c23", 32'(sys_rst), 1);
        check("s4_rdy_c23", 32'(ready), 0);
        check("s4_lcnt_c23", 32'(loss_cnt), st(1));
        check("s4_pll_c23", 32'(pll_rst), 0);
        locked = 1'b1;
        run_until(33);
        check("s4_sys_c33", 32'(sys_rst), 1);
        check("s4_pll_c33", 32'(pll_rst), 0);
        run_until(34);
        check("s4_sys_c34", 32'(sys_rst), 0);
        check("s4_rdy_c34", 32'(ready), 1);
        check("s4_lcnt_c34", 32'(loss_cnt), st(1));
        check("s4_tcnt_c34", 32'(timeout_cnt), 0);

        // Second loss, then reset asserted at STABLE count 6.
        locked = 1'b0;
        run_until(37);
        locked = 1'b1;
        run_until(46);
        check("s5_lcnt_pre", 32'(loss_cnt), st(2));
        check("s5_sys_pre", 32'(sys_rst), 1);
        check("s5_pll_pre", 32'(pll_rst), 0);
        rst = 1'b1;
        tick();
        check("s5_pll_rst", 32'(pll_rst), 1);
        check("s5_sys_rst", 32'(sys_rst), 1);
        check("s5_lcnt_rst", 32'(loss_cnt), 0);
        rst = 1'b0;
        cyc = 0;
        check_release_seq("s5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
